// File: rtl/ifu_mem_req_ctrl.sv
// Single-outstanding IFU miss/prefetch request controller: arbitrates demand vs prefetch,
// issues one tag to memory, matches the returning line and emits a one-cycle fill.
// Optional fill/timeout statistics counters are enabled by defining IFU_MEM_REQ_CTRL_STATS_EN.
module ifu_mem_req_ctrl #(
    parameter int TAG_WIDTH      = 28,
    parameter int LINE_WIDTH     = 128,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                  Clock,
    input  logic                  Rst,
    input  logic                  dem_reqValidIn,
    input  logic [TAG_WIDTH-1:0]  dem_reqTagIn,
    input  logic                  pf_reqValidIn,
    input  logic [TAG_WIDTH-1:0]  pf_reqTagIn,
    output logic                  pf_reqReadyOut,
    output logic                  mem_reqValidOut,
    output logic [TAG_WIDTH-1:0]  mem_reqTagOut,
    input  logic                  mem_reqReadyIn,
    input  logic                  mem_rspValidIn,
    input  logic [TAG_WIDTH-1:0]  mem_rspTagIn,
    input  logic [LINE_WIDTH-1:0] mem_rspInsLineIn,
    output logic                  fill_validOut,
    output logic [TAG_WIDTH-1:0]  fill_tagOut,
    output logic [LINE_WIDTH-1:0] fill_lineOut,
    output logic                  fill_isPrefetchOut,
    output logic                  busyOut,
`ifdef IFU_MEM_REQ_CTRL_STATS_EN
    output logic [15:0]           stat_demFillsOut,
    output logic [15:0]           stat_pfFillsOut,
    output logic [15:0]           stat_timeoutsOut,
`endif
    output logic                  timeoutOut
);

    localparam int TW = $clog2(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, FILL} state_t;

    state_t                state_q, state_d;
    logic [TAG_WIDTH-1:0]  tag_q, tag_d;
    logic [LINE_WIDTH-1:0] line_q, line_d;
    logic                  isPf_q, isPf_d;
    logic [TW-1:0]         timer_q, timer_d;
    logic                  rsp_hit, promote;

    always_ff @(posedge Clock) begin
        if (Rst) begin
            state_q <= IDLE;
            tag_q   <= '0;
            line_q  <= '0;
            isPf_q  <= 1'b0;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            tag_q   <= tag_d;
            line_q  <= line_d;
            isPf_q  <= isPf_d;
            timer_q <= timer_d;
        end
    end

    always_comb begin
        state_d            = state_q;
        tag_d              = tag_q;
        line_d             = line_q;
        isPf_d             = isPf_q;
        timer_d            = timer_q;
        pf_reqReadyOut     = 1'b0;
        mem_reqValidOut    = 1'b0;
        mem_reqTagOut      = '0;
        fill_validOut      = 1'b0;
        fill_tagOut        = '0;
        fill_lineOut       = '0;
        fill_isPrefetchOut = 1'b0;
        timeoutOut         = 1'b0;
        rsp_hit            = mem_rspValidIn && (mem_rspTagIn == tag_q);
        // A demand for the line already being prefetched turns it into a demand fill.
        promote            = isPf_q && dem_reqValidIn && (dem_reqTagIn == tag_q);

        case (state_q)
            IDLE: begin
                if (dem_reqValidIn) begin
                    tag_d   = dem_reqTagIn;
                    isPf_d  = 1'b0;
                    state_d = REQ;
                end else if (pf_reqValidIn) begin
                    pf_reqReadyOut = !Rst;
                    tag_d          = pf_reqTagIn;
                    isPf_d         = 1'b1;
                    state_d        = REQ;
                end
            end
            REQ: begin
                mem_reqValidOut = 1'b1;
                mem_reqTagOut   = tag_q;
                if (promote) isPf_d = 1'b0;
                if (mem_reqReadyIn) begin
                    state_d = WAIT;
                    timer_d = '0;
                end
            end
            WAIT: begin
                if (promote) isPf_d = 1'b0;
                if (rsp_hit) begin
                    line_d  = mem_rspInsLineIn;
                    state_d = FILL;
                    timer_d = '0;
                end else if (timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
                    timeoutOut = 1'b1;
                    state_d    = REQ;
                    timer_d    = '0;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            FILL: begin
                fill_validOut      = 1'b1;
                fill_tagOut        = tag_q;
                fill_lineOut       = line_q;
                fill_isPrefetchOut = isPf_q;
                state_d            = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign busyOut = (state_q != IDLE);

`ifdef IFU_MEM_REQ_CTRL_STATS_EN
    logic [15:0] dem_cnt_q, pf_cnt_q, to_cnt_q;

    always_ff @(posedge Clock) begin
        if (Rst) begin
            dem_cnt_q <= '0;
            pf_cnt_q  <= '0;
            to_cnt_q  <= '0;
        end else begin
            if (fill_validOut && !fill_isPrefetchOut && dem_cnt_q != 16'hFFFF)
                dem_cnt_q <= dem_cnt_q + 16'd1;
            if (fill_validOut && fill_isPrefetchOut && pf_cnt_q != 16'hFFFF)
                pf_cnt_q <= pf_cnt_q + 16'd1;
            if (timeoutOut && to_cnt_q != 16'hFFFF)
                to_cnt_q <= to_cnt_q + 16'd1;
        end
    end

    assign stat_demFillsOut = dem_cnt_q;
    assign stat_pfFillsOut  = pf_cnt_q;
    assign stat_timeoutsOut = to_cnt_q;
`endif

endmodule

// File: tb/tb_ifu_mem_req_ctrl.sv
// Bench for ifu_mem_req_ctrl: directed scenarios with literal expectations, then random
// traffic checked every cycle against a transaction-level model of the request lifecycle.
module tb_ifu_mem_req_ctrl;
    localparam int TW = 28;
    localparam int LW = 128;
    localparam int TO = 8;

    logic          Clock = 1'b0;
    logic          Rst;
    logic          dem_v, pf_v, mrdy, rsp_v;
    logic [TW-1:0] dem_t, pf_t, rsp_t;
    logic [LW-1:0] rsp_line;
    logic          pf_reqReadyOut, mem_reqValidOut, fill_validOut, fill_isPrefetchOut;
    logic          busyOut, timeoutOut;
    logic [TW-1:0] mem_reqTagOut, fill_tagOut;
    logic [LW-1:0] fill_lineOut;
`ifdef IFU_MEM_REQ_CTRL_STATS_EN
    logic [15:0]   stat_demFillsOut, stat_pfFillsOut, stat_timeoutsOut;
`endif

    always #5 Clock = ~Clock;

    ifu_mem_req_ctrl #(.TAG_WIDTH(TW), .LINE_WIDTH(LW), .TIMEOUT_CYCLES(TO)) dut (
        .Clock(Clock), .Rst(Rst),
        .dem_reqValidIn(dem_v), .dem_reqTagIn(dem_t),
        .pf_reqValidIn(pf_v), .pf_reqTagIn(pf_t), .pf_reqReadyOut(pf_reqReadyOut),
        .mem_reqValidOut(mem_reqValidOut), .mem_reqTagOut(mem_reqTagOut),
        .mem_reqReadyIn(mrdy),
        .mem_rspValidIn(rsp_v), .mem_rspTagIn(rsp_t), .mem_rspInsLineIn(rsp_line),
        .fill_validOut(fill_validOut), .fill_tagOut(fill_tagOut),
        .fill_lineOut(fill_lineOut), .fill_isPrefetchOut(fill_isPrefetchOut),
        .busyOut(busyOut),
`ifdef IFU_MEM_REQ_CTRL_STATS_EN
        .stat_demFillsOut(stat_demFillsOut), .stat_pfFillsOut(stat_pfFillsOut),
        .stat_timeoutsOut(stat_timeoutsOut),
`endif
        .timeoutOut(timeoutOut)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    endtask

    // Model: one outstanding transaction; stage 0=none, 1=asking memory, 2=awaiting line, 3=delivering.
    int            m_stage = 0, n_stage = 0;
    logic [TW-1:0] m_tag = '0, n_tag = '0;
    logic [LW-1:0] m_line = '0, n_line = '0;
    logic          m_pf = 1'b0, n_pf = 1'b0;
    int            m_waited = 0, n_waited = 0;
    int            m_dem = 0, m_pfc = 0, m_to = 0, n_dem = 0, n_pfc = 0, n_to = 0;
    bit            m_ok = 1'b0, n_ok = 1'b0;

    always @(negedge Clock) begin
        bit hit, tout;
        hit  = (m_stage == 2) && rsp_v && (rsp_t == m_tag);
        tout = (m_stage == 2) && !hit && (m_waited == TO - 1);
        if (m_ok && !Rst) begin
            chk("busy",    128'(busyOut),            128'(m_stage != 0));
            chk("pfReady", 128'(pf_reqReadyOut),     128'(m_stage == 0 && !dem_v && pf_v));
            chk("memVld",  128'(mem_reqValidOut),    128'(m_stage == 1));
            chk("memTag",  128'(mem_reqTagOut),      128'(m_stage == 1 ? m_tag : '0));
            chk("timeout", 128'(timeoutOut),         128'(tout));
            chk("fillVld", 128'(fill_validOut),      128'(m_stage == 3));
            chk("fillTag", 128'(fill_tagOut),        128'(m_stage == 3 ? m_tag : '0));
            chk("fillLn",  fill_lineOut,             (m_stage == 3) ? m_line : '0);
            chk("fillPf",  128'(fill_isPrefetchOut), 128'(m_stage == 3 && m_pf));
`ifdef IFU_MEM_REQ_CTRL_STATS_EN
            chk("stDem",   128'(stat_demFillsOut),   128'(m_dem));
            chk("stPf",    128'(stat_pfFillsOut),    128'(m_pfc));
            chk("stTo",    128'(stat_timeoutsOut),   128'(m_to));
`endif
        end
        n_stage = m_stage; n_tag = m_tag; n_line = m_line; n_pf = m_pf; n_waited = m_waited;
        n_dem = m_dem; n_pfc = m_pfc; n_to = m_to; n_ok = m_ok;
        if (Rst) begin
            n_stage = 0; n_tag = '0; n_line = '0; n_pf = 1'b0; n_waited = 0;
            n_dem = 0; n_pfc = 0; n_to = 0; n_ok = 1'b1;
        end else begin
            if ((m_stage == 1 || m_stage == 2) && m_pf && dem_v && dem_t == m_tag) n_pf = 1'b0;
            if (m_stage == 0) begin
                if (dem_v)     begin n_tag = dem_t; n_pf = 1'b0; n_stage = 1; end
                else if (pf_v) begin n_tag = pf_t;  n_pf = 1'b1; n_stage = 1; end
            end else if (m_stage == 1) begin
                if (mrdy) begin n_stage = 2; n_waited = 0; end
            end else if (m_stage == 2) begin
                if (hit)       begin n_line = rsp_line; n_stage = 3; end
                else if (tout) begin n_stage = 1; if (m_to < 65535) n_to = m_to + 1; end
                else n_waited = m_waited + 1;
            end else begin
                n_stage = 0;
                if (m_pf) begin if (m_pfc < 65535) n_pfc = m_pfc + 1; end
                else if (m_dem < 65535) n_dem = m_dem + 1;
            end
        end
    end

    always @(posedge Clock) begin
        m_stage = n_stage; m_tag = n_tag; m_line = n_line; m_pf = n_pf; m_waited = n_waited;
        m_dem = n_dem; m_pfc = n_pfc; m_to = n_to; m_ok = n_ok;
    end

    task automatic cyc();
        @(posedge Clock); #1;
    endtask

    task automatic quiet();
        dem_v = 0; pf_v = 0; mrdy = 0; rsp_v = 0;
        dem_t = '0; pf_t = '0; rsp_t = '0; rsp_line = '0;
    endtask

    localparam logic [LW-1:0] L1 = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;

    initial begin
        Rst = 1; quiet();
        repeat (2) @(posedge Clock);
        #1 Rst = 0;
        @(negedge Clock);
        chk("rst_busy", 128'(busyOut), 0); chk("rst_memVld", 128'(mem_reqValidOut), 0);
        chk("rst_fillVld", 128'(fill_validOut), 0);
        cyc();

        // Demand only: fill on cycle 3
        dem_v = 1; dem_t = 28'hABC; mrdy = 1;
        @(negedge Clock); chk("t1_pfReady", 128'(pf_reqReadyOut), 0);
        cyc();
        @(negedge Clock); chk("t1_memVld", 128'(mem_reqValidOut), 1); chk("t1_memTag", 128'(mem_reqTagOut), 128'h0ABC);
        cyc(); dem_v = 0; rsp_v = 1; rsp_t = 28'hABC; rsp_line = L1;
        @(negedge Clock); chk("t1_noFillYet", 128'(fill_validOut), 0);
        cyc(); rsp_v = 0;
        @(negedge Clock); chk("t1_fillVld", 128'(fill_validOut), 1); chk("t1_fillTag", 128'(fill_tagOut), 128'h0ABC);
        chk("t1_fillPf", 128'(fill_isPrefetchOut), 0); chk("t1_fillLn", fill_lineOut, L1);
        cyc(); quiet();

        // Demand beats prefetch
        dem_v = 1; dem_t = 28'h10; pf_v = 1; pf_t = 28'h20; mrdy = 1;
        @(negedge Clock); chk("t2_pfReady0", 128'(pf_reqReadyOut), 0);
        cyc();
        @(negedge Clock); chk("t2_memTag0", 128'(mem_reqTagOut), 128'h10); chk("t2_pfReady1", 128'(pf_reqReadyOut), 0);
        cyc(); dem_v = 0; rsp_v = 1; rsp_t = 28'h10;
        cyc(); rsp_v = 0;
        @(negedge Clock); chk("t2_fillTag0", 128'(fill_tagOut), 128'h10); chk("t2_pfReady2", 128'(pf_reqReadyOut), 0);
        cyc();
        @(negedge Clock); chk("t2_pfReadyIdle", 128'(pf_reqReadyOut), 1);
        cyc(); pf_v = 0;
        @(negedge Clock); chk("t2_memTag1", 128'(mem_reqTagOut), 128'h20);
        cyc(); rsp_v = 1; rsp_t = 28'h20;
        cyc(); rsp_v = 0;
        @(negedge Clock); chk("t2_fillTag1", 128'(fill_tagOut), 128'h20); chk("t2_fillPf1", 128'(fill_isPrefetchOut), 1);
        cyc(); quiet();

        // Stray response ignored
        dem_v = 1; dem_t = 28'h44; mrdy = 1;
        cyc();
        cyc(); dem_v = 0; rsp_v = 1; rsp_t = 28'h55;
        cyc(); rsp_t = 28'h44;
        @(negedge Clock); chk("t3_strayNoFill", 128'(fill_validOut), 0); chk("t3_busy", 128'(busyOut), 1);
        cyc(); rsp_v = 0;
        @(negedge Clock); chk("t3_fillTag", 128'(fill_tagOut), 128'h44); chk("t3_fillVld", 128'(fill_validOut), 1);
        cyc(); quiet();

        // Timeout after TO WAIT cycles, reissue same tag
        dem_v = 1; dem_t = 28'h77; mrdy = 1;
        cyc();
        cyc(); dem_v = 0;
        repeat (TO - 2) cyc();
        @(negedge Clock); chk("t4_noTimeoutYet", 128'(timeoutOut), 0);
        cyc();
        @(negedge Clock); chk("t4_timeout", 128'(timeoutOut), 1);
        cyc();
        @(negedge Clock); chk("t4_reissue", 128'(mem_reqValidOut), 1); chk("t4_reissueTag", 128'(mem_reqTagOut), 128'h77);
        cyc(); rsp_v = 1; rsp_t = 28'h77;
        cyc(); rsp_v = 0;
        @(negedge Clock); chk("t4_fillTag", 128'(fill_tagOut), 128'h77);
        cyc(); quiet();

        // Prefetch promoted by a matching demand
        pf_v = 1; pf_t = 28'h30; mrdy = 1;
        @(negedge Clock); chk("t5_pfReady", 128'(pf_reqReadyOut), 1);
        cyc(); pf_v = 0;
        cyc(); dem_v = 1; dem_t = 28'h30;
        cyc(); rsp_v = 1; rsp_t = 28'h30;
        cyc(); dem_v = 0; rsp_v = 0;
        @(negedge Clock); chk("t5_fillVld", 128'(fill_validOut), 1); chk("t5_fillPf", 128'(fill_isPrefetchOut), 0);
        chk("t5_fillTag", 128'(fill_tagOut), 128'h30);
        cyc(); quiet();
`ifdef IFU_MEM_REQ_CTRL_STATS_EN
        @(negedge Clock); chk("st_dem", 128'(stat_demFillsOut), 5); chk("st_pf", 128'(stat_pfFillsOut), 1);
        chk("st_to", 128'(stat_timeoutsOut), 1);
`endif

        // Reset in WAIT aborts; late response ignored
        dem_v = 1; dem_t = 28'h30; mrdy = 1;
        cyc();
        cyc(); dem_v = 0;
        cyc(); Rst = 1;
        cyc(); Rst = 0; rsp_v = 1; rsp_t = 28'h30;
        @(negedge Clock); chk("t6_busy", 128'(busyOut), 0); chk("t6_memVld", 128'(mem_reqValidOut), 0);
        chk("t6_fillVld", 128'(fill_validOut), 0); chk("t6_timeout", 128'(timeoutOut), 0);
        chk("t6_memTag", 128'(mem_reqTagOut), 0);
        cyc();
        @(negedge Clock); chk("t6_lateNoFill", 128'(fill_validOut), 0);
        cyc(); rsp_v = 0;
        @(negedge Clock); chk("t6_lateNoFill2", 128'(fill_validOut), 0); chk("t6_busy2", 128'(busyOut), 0);

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            cyc();
            Rst      = ($urandom_range(0, 199) == 0);
            dem_v    = ($urandom_range(0, 3) == 0);
            dem_t    = 28'($urandom_range(0, 3));
            pf_v     = 1'($urandom_range(0, 1));
            pf_t     = 28'($urandom_range(0, 3));
            mrdy     = 1'($urandom_range(0, 1));
            rsp_v    = ($urandom_range(0, 9) < 4);
            rsp_t    = ($urandom_range(0, 1) == 1) ? m_tag : 28'($urandom_range(0, 3));
            rsp_line = {$urandom, $urandom, $urandom, $urandom};
        end
        cyc(); quiet(); Rst = 0;
        repeat (2) cyc();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/ifu_mem_req_ctrl.md
Name: ifu_mem_req_ctrl

Overview:
Single-outstanding memory request controller for the IFU instruction cache. Accepts demand-miss requests from the cache and speculative requests from the prefetcher, and issues one tag at a time to the memory port. It matches the returning line by tag and hands it to the cache as a one-cycle fill. Sits between the cache's miss/fill interface and the memory interface, replacing the direct cache-to-memory connection.

Parameters:
TAG_WIDTH, 28, line tag width (address bits above the line offset)
LINE_WIDTH, 128, instruction line width in bits
TIMEOUT_CYCLES, 64, WAIT-state cycles before a request is reissued (>=2)

Ports:
Clock  in  1  clock
Rst  in  1  synchronous, active-high reset
dem_reqValidIn  in  1  cache demand miss; level, held while the miss persists
dem_reqTagIn  in  TAG_WIDTH  demand tag
pf_reqValidIn  in  1  prefetch request; transfers when pf_reqReadyOut=1
pf_reqTagIn  in  TAG_WIDTH  prefetch tag
pf_reqReadyOut  out  1  prefetch accepted this cycle
mem_reqValidOut  out  1  request to memory
mem_reqTagOut  out  TAG_WIDTH  requested tag
mem_reqReadyIn  in  1  memory accepts the request
mem_rspValidIn  in  1  memory response valid
mem_rspTagIn  in  TAG_WIDTH  response tag
mem_rspInsLineIn  in  LINE_WIDTH  response line
fill_validOut  out  1  one-cycle fill strobe to the cache
fill_tagOut  out  TAG_WIDTH  fill tag
fill_lineOut  out  LINE_WIDTH  fill line
fill_isPrefetchOut  out  1  fill originated from the prefetcher
busyOut  out  1  state != IDLE
timeoutOut  out  1  one-cycle pulse on a timeout-driven reissue

Behaviour:
- Clock and reset: single clock Clock; Rst is synchronous and active-high. While Rst=1 at a rising edge: state=IDLE; all outputs, the latched tag/line/flag registers and the timer are cleared to 0.
- Reset mid-operation aborts the in-flight request. Responses arriving afterwards are ignored because the FSM is in IDLE.
- FSM states: IDLE, REQ, WAIT, FILL.
- IDLE:
  - If dem_reqValidIn=1: latch dem_reqTagIn, set isPf=0, go to REQ.
  - Else if pf_reqValidIn=1: pf_reqReadyOut=1 (combinational), latch pf_reqTagIn, set isPf=1, go to REQ.
  - Demand always wins a simultaneous arbitration; pf_reqReadyOut=0 whenever dem_reqValidIn=1 or state!=IDLE.
- REQ: mem_reqValidOut=1 and mem_reqTagOut=latched tag, both held stable until mem_reqReadyIn=1. On acceptance go to WAIT and clear the timer.
- WAIT:
  - On mem_rspValidIn=1 with mem_rspTagIn==latched tag: capture the line and go to FILL.
  - Responses with a non-matching tag are ignored.
  - The timer increments each cycle in WAIT. When timer==TIMEOUT_CYCLES-1 and no matching response arrives that cycle: pulse timeoutOut and go to REQ (reissue the same tag).
  - A matching response in that same cycle wins over the timeout.
- FILL: fill_validOut=1 for exactly one cycle with the latched tag, captured line and isPf; then go to IDLE.
- Prefetch promotion: in REQ or WAIT with isPf=1, if dem_reqValidIn=1 and dem_reqTagIn==latched tag, clear isPf. The fill is then delivered as a demand fill.
- A demand with a different tag waits for IDLE, which takes priority.
- Responses in IDLE, REQ or FILL are ignored, including a response arriving in the same cycle as mem_reqReadyIn.
- Minimum demand latency: request seen in IDLE at cycle 0 → mem_reqValidOut at cycle 1 → accepted at cycle 1 → response at cycle 2 → fill_validOut at cycle 3.
- Back-to-back: the cycle after FILL is IDLE, so a new request is accepted there. Throughput is at most one fill per 4 cycles.
- The timer is $clog2(TIMEOUT_CYCLES) bits wide and never wraps (it is cleared on leaving WAIT).

Optional Feature:
IFU_MEM_REQ_CTRL_STATS_EN
- Defined: adds outputs stat_demFillsOut, stat_pfFillsOut and stat_timeoutsOut, 16 bits each.
  - stat_demFillsOut / stat_pfFillsOut increment on each fill cycle, selected by fill_isPrefetchOut.
  - stat_timeoutsOut increments on each timeoutOut pulse.
  - All three saturate at 16'hFFFF and are cleared by Rst.
- Undefined: these ports and counters are absent; all other behaviour is identical.

Test Plan:
- Demand only: dem tag 0x0000ABC in IDLE, mem_reqReadyIn=1, matching response next cycle → fill_validOut at cycle 3, fill_tagOut=0x0000ABC, fill_isPrefetchOut=0.
- Simultaneous demand 0x10 and prefetch 0x20 → 0x10 issued first, pf_reqReadyOut=0. 0x20 is accepted only after the fill, if still asserted.
- Stray response: tag 0x55 while waiting for 0x44 → ignored; the later 0x44 response fills.
- Timeout with TIMEOUT_CYCLES=8 and no response → timeoutOut pulses after 8 WAIT cycles and mem_reqValidOut reasserts with the same tag.
- Promotion: prefetch 0x30 in WAIT, then demand 0x30 → fill with fill_isPrefetchOut=0.
- Reset asserted in WAIT → next cycle busyOut=0 and all outputs 0; a late 0x30 response produces no fill.
